memory_stage: RTL and testbench

Memory (M) stage of the five-stage MIPS pipeline, directly downstream of execute. Latches the execute outputs into the M pipeline register, drives the data bus through a request/response handshake, and formats store strobes/data and load extension. Forwards `ALUOutM` back to execute and raises a busy stall to the hazard unit while a bus transaction is outstanding.

---
 rtl/memory_stage_pkg.sv | 62 ++++++
 rtl/memory_stage_min.sv | 54 +++++
 rtl/memory_stage.sv | 197 +++++++++++++++++++
 tb/tb_memory_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
//   Types and helpers shared by the M stage of the MIPS pipeline.
//   mem_t    : access kind carried from execute
//   mstate_t : data-bus transaction FSM states
//   MSIZE_*  : dreq_size encodings
package memory_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB,
    LBU,
    LH,
    LHU,
    LW,
    SB,
    SH,
    SW
  } mem_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2,
    DRAIN     = 2'd3
  } mstate_t;

  localparam logic [2:0] MSIZE_BYTE = 3'd0;
  localparam logic [2:0] MSIZE_HALF = 3'd1;
  localparam logic [2:0] MSIZE_WORD = 3'd2;

  function automatic logic isLoad(input mem_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic isStore(input mem_t op);
    return op inside {SB, SH, SW};
  endfunction

  // Select the addressed byte/half of the returned bus word and extend it.
  function automatic logic [31:0] extendLoad(input mem_t op, input logic [1:0] lowAddr,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lowAddr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lowAddr[1] ? word[31:16] : word[15:0];
    case (op)
      LB:      r = {{24{b[7]}}, b};
      LBU:     r = {24'h0, b};
      LH:      r = {{16{h[15]}}, h};
      LHU:     r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_stage_min.sv
// memory_stage_min
//   M pipeline register between execute and memory.
//   Holds when StallM, loads a bubble (all zeros, MEM_NONE) when FlushM,
//   which wins over StallM. Async active-low reset clears it.
//   Inputs : clk, resetn, StallM, FlushM, E-stage values (*E)
//   Outputs: registered copies (*M); RegWriteM here is before address-error gating
module memory_stage_min (
  input  logic        clk,
  input  logic        resetn,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] PCE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [3:0]  MemOpE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  output logic [31:0] PCM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [3:0]  MemOpM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn || FlushM) begin
      if (!resetn || FlushM) begin
        PCM        <= '0;
        RegWriteM  <= 1'b0;
        MemtoRegM  <= 1'b0;
        MemWriteM  <= 1'b0;
        MemOpM     <= '0;
        WriteRegM  <= '0;
        ALUOutM    <= '0;
        WriteDataM <= '0;
      end
    end else if (!StallM) begin
      PCM        <= PCE;
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      MemOpM     <= MemOpE;
      WriteRegM  <= WriteRegE;
      ALUOutM    <= ALUOutE;
      WriteDataM <= WriteDataE;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage
//   Memory stage of the five-stage MIPS pipeline. Latches execute outputs,
//   runs one data-bus request/response transaction per load/store, formats
//   store strobes/data and extends load data.
//   Optional feature: define MEM_ADDR_ERROR_EN to flag misaligned half/word
//   accesses on AdErrM (request suppressed, RegWriteM forced low). Without it
//   AdErrM is 0 and low address bits are masked to natural alignment.
//   Ports:
//     clk, resetn                      clock, async active-low reset
//     StallM, FlushM                   hazard unit hold / bubble
//     PCE..WriteDataE                  execute-stage inputs
//     PCM, WriteRegM, RegWriteM,
//     MemtoRegM, ALUOutM, ReadDataM    to writeback / forward path
//     MemBusyM                         stall request while bus is outstanding
//     AdErrM                           misaligned access flag
//     dreq_*, dresp_*                  data-bus handshake
//
//   state     | meaning
//   IDLE      | request issued here when M holds a memory op
//   WAIT_DATA | address accepted, waiting for data_ok
//   DONE      | data captured, waiting for the M register to advance
//   DRAIN     | flushed while outstanding, discarding the response
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] PCE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [3:0]  MemOpE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  output logic [31:0] PCM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        AdErrM,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  logic [3:0]  memOpBits;
  mem_t        MemOpM;
  logic        regWriteRaw;
  logic        MemWriteM;
  logic [31:0] WriteDataM;
  logic        adErr;
  logic        memOp;
  logic        capture;
  logic [31:0] effAddr;
  mstate_t     state, stateNext;

  memory_stage_min Min (
    .clk        (clk),
    .resetn     (resetn),
    .StallM     (StallM),
    .FlushM     (FlushM),
    .PCE        (PCE),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .MemOpE     (MemOpE),
    .WriteRegE  (WriteRegE),
    .ALUOutE    (ALUOutE),
    .WriteDataE (WriteDataE),
    .PCM        (PCM),
    .RegWriteM  (regWriteRaw),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .MemOpM     (memOpBits),
    .WriteRegM  (WriteRegM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM)
  );

  assign MemOpM = mem_t'(memOpBits);

`ifdef MEM_ADDR_ERROR_EN
  always_comb begin
    adErr = 1'b0;
    case (MemOpM)
      LH, LHU, SH: adErr = ALUOutM[0];
      LW, SW:      adErr = |ALUOutM[1:0];
      default:     adErr = 1'b0;
    endcase
  end
  assign effAddr = ALUOutM;
`else
  assign adErr = 1'b0;
  always_comb begin
    effAddr = ALUOutM;
    case (MemOpM)
      LH, LHU, SH: effAddr[0]   = 1'b0;
      LW, SW:      effAddr[1:0] = 2'b00;
      default:     effAddr      = ALUOutM;
    endcase
  end
`endif

  assign AdErrM    = adErr;
  assign RegWriteM = regWriteRaw & ~adErr;
  assign memOp     = (isLoad(MemOpM) | (isStore(MemOpM) & MemWriteM)) & ~adErr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // A flush that coincides with the response drops the data; a flush after
  // address acceptance must still absorb the pending data_ok (DRAIN).
  always_comb begin
    stateNext  = state;
    dreq_valid = 1'b0;
    MemBusyM   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        dreq_valid = memOp;
        MemBusyM   = memOp;
        if (memOp && dresp_addr_ok) begin
          if (dresp_data_ok) begin
            stateNext = FlushM ? IDLE : DONE;
            capture   = ~FlushM;
          end else begin
            stateNext = FlushM ? DRAIN : WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        MemBusyM = memOp;
        if (dresp_data_ok) begin
          stateNext = FlushM ? IDLE : DONE;
          capture   = ~FlushM;
        end else if (FlushM) begin
          stateNext = DRAIN;
        end
      end
      DONE: begin
        if (FlushM || !StallM) stateNext = IDLE;
      end
      DRAIN: begin
        MemBusyM = 1'b1;
        if (dresp_data_ok) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ReadDataM <= '0;
    else if (capture && isLoad(MemOpM))
      ReadDataM <= extendLoad(MemOpM, effAddr[1:0], dresp_data);
  end

  assign dreq_addr = effAddr;

  always_comb begin
    dreq_size   = MSIZE_BYTE;
    dreq_strobe = 4'h0;
    dreq_data   = WriteDataM;
    case (MemOpM)
      LB, LBU: dreq_size = MSIZE_BYTE;
      LH, LHU: dreq_size = MSIZE_HALF;
      LW:      dreq_size = MSIZE_WORD;
      SB: begin
        dreq_size   = MSIZE_BYTE;
        dreq_strobe = 4'b0001 << effAddr[1:0];
        dreq_data   = {4{WriteDataM[7:0]}};
      end
      SH: begin
        dreq_size   = MSIZE_HALF;
        dreq_strobe = 4'b0011 << {effAddr[1], 1'b0};
        dreq_data   = {2{WriteDataM[15:0]}};
      end
      SW: begin
        dreq_size   = MSIZE_WORD;
        dreq_strobe = 4'hF;
      end
      default: dreq_size = MSIZE_BYTE;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Scoreboarded bench for memory_stage: expected ReadDataM values are queued
//   when an access is issued and compared when the bus transaction completes.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        StallM, FlushM = 1'b0;
  logic [31:0] PCE = '0;
  logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0;
  logic [3:0]  MemOpE = '0;
  logic [4:0]  WriteRegE = '0;
  logic [31:0] ALUOutE = '0, WriteDataE = '0;
  logic [31:0] PCM, ALUOutM, ReadDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM, MemBusyM, AdErrM;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastRead = '0;

  always #5 clk = ~clk;

  // hazard unit: M stalls on its own busy
  assign StallM = MemBusyM;

  memory_stage dut (
    .clk(clk), .resetn(resetn), .StallM(StallM), .FlushM(FlushM),
    .PCE(PCE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .MemOpE(MemOpE), .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .PCM(PCM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .MemBusyM(MemBusyM), .AdErrM(AdErrM),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input mem_t op, input logic [31:0] addr,
                                          input logic [31:0] w);
    logic [31:0] s;
    case (op)
      LB:  begin s = w >> (8 * addr[1:0]); return {{24{s[7]}}, s[7:0]}; end
      LBU: begin s = w >> (8 * addr[1:0]); return {24'h0, s[7:0]}; end
      LH:  begin s = w >> (16 * addr[1]); return {{16{s[15]}}, s[15:0]}; end
      LHU: begin s = w >> (16 * addr[1]); return {16'h0, s[15:0]}; end
      default: return w;
    endcase
  endfunction

  task automatic bubbleE();
    PCE = '0; MemOpE = '0; ALUOutE = '0; WriteDataE = '0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0; WriteRegE = '0;
  endtask

  // Present one instruction in E for one cycle; returns at the negedge after it entered M.
  task automatic issue(input mem_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc);
    @(negedge clk);
    PCE = pc; MemOpE = op; ALUOutE = addr; WriteDataE = wd;
    RegWriteE = !isStore(op); MemtoRegE = isLoad(op); MemWriteE = isStore(op);
    WriteRegE = isStore(op) ? 5'd0 : 5'd9;
    @(negedge clk);
    bubbleE();
  endtask

  // Bus responder: addr_ok after aDelay cycles, data_ok dDelay cycles later.
  task automatic busTxn(input string tag, input logic [31:0] expAddr, input int aDelay,
                        input int dDelay, input logic [31:0] rdata, input int expBusy);
    int cyc = 0;
    int busy = 0;
    logic [31:0] expRead;
    while (MemBusyM && cyc < 40) begin
      busy++;
      if (cyc <= aDelay) begin
        checkVal({tag, ".valid"}, {31'd0, dreq_valid}, 32'd1);
        checkVal({tag, ".addr"}, dreq_addr, expAddr);
      end
      dresp_addr_ok = (cyc == aDelay);
      dresp_data_ok = (cyc == aDelay + dDelay);
      dresp_data    = rdata;
      @(negedge clk);
      cyc++;
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    if (cyc >= 40) checkVal({tag, ".timeout"}, 32'd1, 32'd0);
    checkVal({tag, ".busy"}, busy, expBusy);
    checkVal({tag, ".validDone"}, {31'd0, dreq_valid}, 32'd0);
    expRead = expQ.pop_front();
    checkVal({tag, ".rdata"}, ReadDataM, expRead);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    checkVal("rst.PCM", PCM, 32'h0);
    checkVal("rst.ALUOutM", ALUOutM, 32'h0);
    checkVal("rst.ReadDataM", ReadDataM, 32'h0);
    checkVal("rst.ctl", {26'd0, dreq_valid, MemBusyM, AdErrM, RegWriteM, MemtoRegM, 1'b0}, 32'h0);
    resetn = 1'b1;

    // non-memory pass-through
    issue(MEM_NONE, 32'h0000_1234, 32'h0, 32'h0000_0400);
    checkVal("alu.ALUOutM", ALUOutM, 32'h0000_1234);
    checkVal("alu.PCM", PCM, 32'h0000_0400);
    checkVal("alu.wr", {26'd0, WriteRegM, RegWriteM}, {26'd0, 5'd9, 1'b1});
    checkVal("alu.busy", {30'd0, MemBusyM, dreq_valid}, 32'h0);

    // SW, same-cycle response
    issue(SW, 32'h100, 32'hDEAD_BEEF, 32'h0000_0404);
    checkVal("sw.strobe", {28'd0, dreq_strobe}, 32'hF);
    checkVal("sw.size", {29'd0, dreq_size}, 32'd2);
    checkVal("sw.data", dreq_data, 32'hDEAD_BEEF);
    expQ.push_back(lastRead);
    busTxn("sw", 32'h100, 0, 0, 32'h0, 1);

    // SB at 0x103, addr_ok held off two cycles (request must stay stable)
    issue(SB, 32'h103, 32'h0000_00A5, 32'h0000_0408);
    checkVal("sb.strobe", {28'd0, dreq_strobe}, 32'h8);
    checkVal("sb.size", {29'd0, dreq_size}, 32'd0);
    checkVal("sb.data", dreq_data, 32'hA5A5_A5A5);
    expQ.push_back(lastRead);
    busTxn("sb", 32'h103, 2, 0, 32'h0, 3);

    // LB at 0x102, data_ok three cycles after addr_ok
    issue(LB, 32'h102, 32'h0, 32'h0000_040C);
    checkVal("lb.strobe", {28'd0, dreq_strobe}, 32'h0);
    checkVal("lb.memtoreg", {31'd0, MemtoRegM}, 32'd1);
    lastRead = refLoad(LB, 32'h102, 32'h0080_0000);
    expQ.push_back(lastRead);
    busTxn("lb", 32'h102, 0, 3, 32'h0080_0000, 4);

    // LHU at 0x102
    issue(LHU, 32'h102, 32'h0, 32'h0000_0410);
    checkVal("lhu.size", {29'd0, dreq_size}, 32'd1);
    lastRead = refLoad(LHU, 32'h102, 32'h8001_1234);
    expQ.push_back(lastRead);
    busTxn("lhu", 32'h102, 0, 1, 32'h8001_1234, 2);

    // LH at 0x100, sign extension
    issue(LH, 32'h100, 32'h0, 32'h0000_0414);
    lastRead = refLoad(LH, 32'h100, 32'h0000_F00F);
    expQ.push_back(lastRead);
    busTxn("lh", 32'h100, 1, 0, 32'h0000_F00F, 2);

    // SH at 0x102
    issue(SH, 32'h102, 32'h0000_BEEF, 32'h0000_0418);
    checkVal("sh.strobe", {28'd0, dreq_strobe}, 32'hC);
    checkVal("sh.data", dreq_data, 32'hBEEF_BEEF);
    expQ.push_back(lastRead);
    busTxn("sh", 32'h102, 0, 0, 32'h0, 1);

    // misaligned LW at 0x101
    issue(LW, 32'h101, 32'h0, 32'h0000_041C);
`ifdef MEM_ADDR_ERROR_EN
    checkVal("lwmis.aderr", {31'd0, AdErrM}, 32'd1);
    checkVal("lwmis.valid", {31'd0, dreq_valid}, 32'd0);
    checkVal("lwmis.regwrite", {31'd0, RegWriteM}, 32'd0);
    checkVal("lwmis.busy", {31'd0, MemBusyM}, 32'd0);
`else
    checkVal("lwmis.aderr", {31'd0, AdErrM}, 32'd0);
    lastRead = refLoad(LW, 32'h100, 32'hCAFE_F00D);
    expQ.push_back(lastRead);
    busTxn("lwmis", 32'h100, 0, 0, 32'hCAFE_F00D, 1);
`endif

    // flush while waiting for data: DRAIN holds busy, data discarded
    issue(LW, 32'h200, 32'h0, 32'h0000_0420);
    checkVal("fl.valid", {31'd0, dreq_valid}, 32'd1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    checkVal("fl.wait", {30'd0, dreq_valid, MemBusyM}, 32'd1);
    FlushM = 1'b1;
    @(negedge clk);
    FlushM = 1'b0;
    checkVal("fl.drainBusy", {31'd0, MemBusyM}, 32'd1);
    checkVal("fl.bubble", {31'd0, RegWriteM}, 32'd0);
    @(negedge clk);
    checkVal("fl.drainBusy2", {31'd0, MemBusyM}, 32'd1);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h1234_5678;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    checkVal("fl.idleBusy", {31'd0, MemBusyM}, 32'd0);
    checkVal("fl.rdata", ReadDataM, lastRead);

    // reset mid-request
    issue(SW, 32'h300, 32'h1111_2222, 32'h0000_0424);
    checkVal("rmid.valid", {31'd0, dreq_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    checkVal("rmid.ctl", {30'd0, dreq_valid, MemBusyM}, 32'd0);
    checkVal("rmid.ALUOutM", ALUOutM, 32'h0);
    checkVal("rmid.PCM", PCM, 32'h0);
    checkVal("rmid.ReadDataM", ReadDataM, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    lastRead = '0;

    // recovery after reset: LBU
    issue(LBU, 32'h301, 32'h0, 32'h0000_0428);
    lastRead = refLoad(LBU, 32'h301, 32'h0000_9A00);
    expQ.push_back(lastRead);
    busTxn("lbu", 32'h301, 0, 0, 32'h0000_9A00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
